// File: rtl/latch_wr_seq_if.sv
// Stream-in / latch-write-out bundle for the latch write sequencer.
// The slave modport is the sequencer; the master modport is the upstream producer and observer.
interface latch_wr_seq_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          clr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW:0]   wr_cnt;
    logic          full;
    logic          busy;

    modport slave (
        input  in_valid, in_data, clr,
        output in_ready, wr_en, wr_addr, wr_data, wr_cnt, full, busy
    );

    modport master (
        output in_valid, in_data, clr,
        input  in_ready, wr_en, wr_addr, wr_data, wr_cnt, full, busy
    );
endinterface

// File: rtl/latch_wr_seq.sv
// Write sequencer for a transparent-latch array: setup / open / hold around every wr_en pulse.
// Latency: accept edge -> wr_en high one edge later for OPEN_CYC cycles; one word per 3+OPEN_CYC cycles.
// Backpressure: in_ready low outside IDLE, while full (WRAP=0), and while a clear is requested or pending.
module latch_wr_seq #(
    parameter int DW       = 8,
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int OPEN_CYC = 1,
    parameter int WRAP     = 0
) (
    input  logic          clk,
    input  logic          rstn,
    latch_wr_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [1:0]  OPEN_LD = 2'(OPEN_CYC - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [1:0]    open_cnt_q, open_cnt_d;
    logic          clr_pend_q, clr_pend_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic [AW:0]   wr_cnt_q, wr_cnt_d;
    logic          full_q, full_d;
    logic [AW:0]   cnt_inc;
    logic          in_ready;
    logic          accept;

    assign in_ready = (state_q == IDLE) && !full_q && !bus.clr && !clr_pend_q;
    assign accept   = bus.in_valid && in_ready;
    assign cnt_inc  = (wr_cnt_q == DEPTH_C) ? wr_cnt_q : wr_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        open_cnt_d = open_cnt_q;
        clr_pend_d = clr_pend_q;
        wr_en_d    = wr_en_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_cnt_d   = wr_cnt_q;
        full_d     = full_q;

        // A clear seen mid-write is deferred so the entry in flight completes untouched.
        if (state_q != IDLE && bus.clr) begin
            clr_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.clr) begin
                    ptr_d    = '0;
                    wr_cnt_d = '0;
                    full_d   = 1'b0;
                end else if (accept) begin
                    state_d   = SETUP;
                    wr_addr_d = ptr_q;
                    wr_data_d = bus.in_data;
                end
            end
            SETUP: begin
                state_d    = OPEN;
                wr_en_d    = 1'b1;
                open_cnt_d = OPEN_LD;
            end
            OPEN: begin
                if (open_cnt_q == 2'd0) begin
                    state_d = HOLD;
                    wr_en_d = 1'b0;
                end else begin
                    open_cnt_d = open_cnt_q - 2'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
                if (clr_pend_q || bus.clr) begin
                    ptr_d      = '0;
                    wr_cnt_d   = '0;
                    full_d     = 1'b0;
                    clr_pend_d = 1'b0;
                end else begin
                    ptr_d    = ptr_q + 1'b1;
                    wr_cnt_d = cnt_inc;
                    full_d   = (WRAP == 0) && (cnt_inc == DEPTH_C);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            open_cnt_q <= 2'd0;
            clr_pend_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_cnt_q   <= '0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            open_cnt_q <= open_cnt_d;
            clr_pend_q <= clr_pend_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_cnt_q   <= wr_cnt_d;
            full_q     <= full_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.wr_cnt   = wr_cnt_q;
    assign bus.full     = full_q;
    assign bus.busy     = (state_q != IDLE);

    // The latch is transparent while wr_en is high, so address/data must not move around it.
    wr_stable_a: assert property (@(posedge clk) disable iff (!rstn)
        (wr_en_q || wr_en_d) |-> (wr_addr_d == wr_addr_q) && (wr_data_d == wr_data_q));
endmodule
